// File: rtl/fft_mul_pipe_sat.sv
// -----------------------------------------------------------------------------
// fft_mul_pipe_sat
//   Pipelined signed multiplier for the FFT butterfly (sample x twiddle).
//   The full-precision product is arithmetically right-shifted by SHIFT and
//   saturated to dout_WIDTH bits. A sticky overflow flag records saturation.
//
//   Optional build macro: FFT_MUL_ROUND_EN
//     defined   -> round-half-up before the shift: (P + 2^(SHIFT-1)) >>> SHIFT
//     undefined -> truncation toward -inf: P >>> SHIFT
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   ce         pipeline clock enable; 0 freezes every pipeline register
//   in_valid   din0/din1 carry a sample (sampled only when ce=1)
//   din0       signed operand 0 (data sample), din0_WIDTH bits
//   din1       signed operand 1 (twiddle), din1_WIDTH bits
//   out_valid  dout holds a new result
//   dout       scaled, saturated product, dout_WIDTH bits
//   ovf        sticky flag, set when an output result saturates
//   ovf_clr    synchronous clear of ovf (a coincident set wins)
//
// Pipeline shape (NUM_STAGE registers from input to output):
//   NUM_STAGE = 1 : multiply/scale/saturate -> dout
//   NUM_STAGE = 2 : operand regs -> multiply/scale/saturate -> dout
//   NUM_STAGE >= 3: operand regs -> product regs (NUM_STAGE-2) -> dout
// -----------------------------------------------------------------------------
module fft_mul_pipe_sat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 16,
  parameter int SHIFT      = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  // Working width for scaling: one guard bit over the product so the rounding
  // add cannot wrap, and wide enough to hold the saturation limits.
  localparam int XW = (PW + 1 > dout_WIDTH + 1) ? PW + 1 : dout_WIDTH + 1;

  localparam logic signed [XW-1:0] MAXV =
    {{(XW - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = ~MAXV;

`ifdef FFT_MUL_ROUND_EN
  localparam logic signed [XW-1:0] RND =
    (SHIFT > 0) ? (XW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

  // Returns {saturated, value}.
  function automatic logic [dout_WIDTH:0] scale_sat(input logic signed [PW-1:0] p);
    logic signed [XW-1:0] s;
    s = XW'(p);
`ifdef FFT_MUL_ROUND_EN
    s = s + RND;
`endif
    s = s >>> SHIFT;
    if (s > MAXV) begin
      return {1'b1, MAXV[dout_WIDTH-1:0]};
    end else if (s < MINV) begin
      return {1'b1, MINV[dout_WIDTH-1:0]};
    end else begin
      return {1'b0, s[dout_WIDTH-1:0]};
    end
  endfunction

  // v[k] is the valid bit travelling alongside pipeline register k;
  // v[NUM_STAGE-1] belongs to dout.
  logic [NUM_STAGE-1:0]   v;
  logic signed [PW-1:0]   p_last;   // product feeding the output register
  logic                   last_vin; // valid of p_last
  logic [dout_WIDTH:0]    res;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
    end else if (ce) begin
      v[0] <= in_valid;
      for (int k = 1; k < NUM_STAGE; k++) begin
        v[k] <= v[k-1];
      end
    end
  end

  generate
    if (NUM_STAGE == 1) begin : g_one
      assign p_last   = $signed(din0) * $signed(din1);
      assign last_vin = in_valid;
    end else begin : g_deep
      logic signed [din0_WIDTH-1:0] a_r;
      logic signed [din1_WIDTH-1:0] b_r;

      // NOTE: datapath registers carry no reset; nothing reads them unless the
      // matching valid bit (which is reset) says they hold a sample.
      always_ff @(posedge clk) begin
        if (ce && in_valid) begin
          a_r <= din0;
          b_r <= din1;
        end
      end

      if (NUM_STAGE == 2) begin : g_two
        assign p_last = a_r * b_r;
      end else begin : g_many
        logic signed [PW-1:0] p_pipe [NUM_STAGE-2];

        always_ff @(posedge clk) begin
          if (ce) begin
            if (v[0]) p_pipe[0] <= a_r * b_r;
            for (int j = 1; j < NUM_STAGE - 2; j++) begin
              if (v[j]) p_pipe[j] <= p_pipe[j-1];
            end
          end
        end

        assign p_last = p_pipe[NUM_STAGE-3];
      end

      assign last_vin = v[NUM_STAGE-2];
    end
  endgenerate

  assign res       = scale_sat(p_last);
  assign out_valid = v[NUM_STAGE-1];

  // Output register: dout keeps the last valid result across bubbles/stalls.
  // ovf_clr is honoured regardless of ce; a simultaneous set takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
      ovf  <= 1'b0;
    end else begin
      if (ce && last_vin) dout <= res[dout_WIDTH-1:0];
      if (ce && last_vin && res[dout_WIDTH]) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
